// File: rtl/rans_pkg.sv
// rans_pkg: shared definitions for the rANS frequency-table loader.
//   loader_state_e  - loader FSM state encoding
//   AXI_RESP_OKAY   - AXI-lite OKAY response code
//   restart_addr()  - control-port address of the encoder restart register
//   pack_wdata()    - packs {freq, cum_freq} into one 32-bit table word
package rans_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_RESP,
    ST_RST_WRITE,
    ST_RST_RESP,
    ST_DONE
  } loader_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // The restart register sits just past the last table entry.
  function automatic int unsigned restart_addr(input int unsigned sym_width);
    return 32'd1 << sym_width;
  endfunction

  // wdata[2R-1:R] = freq, wdata[R-1:0] = cum (truncated to R bits), rest 0.
  function automatic logic [31:0] pack_wdata(input logic [31:0] freq,
                                             input logic [31:0] cum,
                                             input int unsigned res);
    logic [31:0] mask;
    mask = (32'd1 << res) - 32'd1;
    return ((freq & mask) << res) | (cum & mask);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-lite bundle, parameterised address/data width.
//   aclk        - channel clock, driven by the master side
//   AW/W/B      - write address, write data, write response channels
//   AR/R        - read channels
// Modports: master, slave.
interface axi_lite_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);

  logic                  aclk;

  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output aclk,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/rans_axil_write_master.sv
// rans_axil_write_master: single-outstanding AXI-lite write engine.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   req, addr, data    - one-cycle request; addr/data captured on req
//   wr_done            - AW and W phases both complete this cycle
//   done, resp         - B handshake this cycle, with its response code
//   awvalid/awaddr/awready, wvalid/wdata/wready, bvalid/bresp/bready
//                      - write channels towards the slave (all registered)
// The owner must only pulse req while no transaction is in flight.
module rans_axil_write_master #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              wr_done,
  output logic              done,
  output logic [1:0]        resp,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready
);

  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_fin;
  logic              w_fin;

  // A channel counts as finished once its valid has dropped or is being
  // accepted now; the phase ends when both are finished.
  always_comb begin
    aw_fin  = !awvalid_q || awready;
    w_fin   = !wvalid_q || wready;
    wr_done = (awvalid_q || wvalid_q) && aw_fin && w_fin;
    done    = bready_q && bvalid;
    resp    = bresp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      if (req) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awaddr_q  <= addr;
        wdata_q   <= data;
      end else begin
        if (awvalid_q && awready) begin
          awvalid_q <= 1'b0;
        end
        if (wvalid_q && wready) begin
          wvalid_q <= 1'b0;
        end
      end
      if (wr_done) begin
        bready_q <= 1'b1;
      end else if (bready_q && bvalid) begin
        bready_q <= 1'b0;
      end
    end
  end

  assign awvalid = awvalid_q;
  assign awaddr  = awaddr_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign bready  = bready_q;

endmodule

// File: rtl/rans_table_loader.sv
// rans_table_loader: programs the rANS encoder frequency table over AXI-lite.
// Takes one frequency per symbol (symbol order) on a valid/ready stream,
// builds cumulative frequencies, writes {freq, cum_freq} per symbol, then
// writes the restart register.
//   clk_i, rst_ni     - clock (also mem_if.aclk), async active-low reset
//   start_i           - begin a load; ignored while busy_o
//   freq_valid_i/freq_ready_o/freq_i - frequency entry stream
//   busy_o            - load in progress (start+1 through the done cycle)
//   done_o            - one-cycle pulse at end of load
//   err_o             - sticky error, cleared by an accepted start_i
//   mem_if            - AXI-lite master, write channels only
// Build option: RANS_LOADER_SUM_CHECK_EN - when defined, a table whose total
// is not 2^RESOLUTION is flagged as an error and the restart write skipped.
module rans_table_loader
  import rans_pkg::*;
#(
  parameter int unsigned RESOLUTION   = 10,
  parameter int unsigned SYMBOL_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  freq_valid_i,
  output logic                  freq_ready_o,
  input  logic [RESOLUTION-1:0] freq_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  axi_lite_if.master            mem_if
);

  localparam int unsigned ADDR_W = SYMBOL_WIDTH + 1;
  localparam logic [ADDR_W-1:0]       RESTART_WADDR = ADDR_W'(restart_addr(SYMBOL_WIDTH));
  localparam logic [SYMBOL_WIDTH-1:0] LAST_SYM      = '1;

  loader_state_e           state_q, state_d;
  logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
  logic [RESOLUTION:0]     acc_q, acc_d;
  logic                    err_q, err_d;

  logic                    req;
  logic [ADDR_W-1:0]       req_addr;
  logic [31:0]             req_data;
  logic                    wr_done;
  logic                    txn_done;
  logic [1:0]              txn_resp;
  logic                    sum_bad;

`ifdef RANS_LOADER_SUM_CHECK_EN
  localparam logic [RESOLUTION:0] FULL_SCALE = {1'b1, {RESOLUTION{1'b0}}};
  assign sum_bad = (acc_q != FULL_SCALE);
`else
  assign sum_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sym_d        = sym_q;
    acc_d        = acc_q;
    err_d        = err_q;
    req          = 1'b0;
    req_addr     = '0;
    req_data     = '0;
    freq_ready_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sym_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        freq_ready_o = 1'b1;
        if (freq_valid_i) begin
          // cum_freq is the accumulator before this symbol's frequency.
          req      = 1'b1;
          req_addr = {1'b0, sym_q};
          req_data = pack_wdata(32'(freq_i), 32'(acc_q), RESOLUTION);
          acc_d    = acc_q + {1'b0, freq_i};
          state_d  = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (wr_done) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (txn_done) begin
          if (txn_resp != AXI_RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (sym_q != LAST_SYM) begin
            sym_d   = sym_q + 1'b1;
            state_d = ST_FETCH;
          end else if (sum_bad) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            req      = 1'b1;
            req_addr = RESTART_WADDR;
            req_data = '0;
            state_d  = ST_RST_WRITE;
          end
        end
      end

      ST_RST_WRITE: begin
        if (wr_done) begin
          state_d = ST_RST_RESP;
        end
      end

      ST_RST_RESP: begin
        if (txn_done) begin
          if (txn_resp != AXI_RESP_OKAY) begin
            err_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign err_o = err_q;

  rans_axil_write_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_wr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req),
    .addr    (req_addr),
    .data    (req_data),
    .wr_done (wr_done),
    .done    (txn_done),
    .resp    (txn_resp),
    .awvalid (mem_if.awvalid),
    .awaddr  (mem_if.awaddr),
    .awready (mem_if.awready),
    .wvalid  (mem_if.wvalid),
    .wdata   (mem_if.wdata),
    .wready  (mem_if.wready),
    .bvalid  (mem_if.bvalid),
    .bresp   (mem_if.bresp),
    .bready  (mem_if.bready)
  );

  assign mem_if.aclk    = clk_i;
  assign mem_if.awprot  = '0;
  assign mem_if.wstrb   = '1;
  assign mem_if.araddr  = '0;
  assign mem_if.arprot  = '0;
  assign mem_if.arvalid = 1'b0;
  assign mem_if.rready  = 1'b1;

  // Read channel inputs are not used by a write-only master.
  logic unused_rd;
  assign unused_rd = &{1'b0, mem_if.arready, mem_if.rdata, mem_if.rresp, mem_if.rvalid};

endmodule

// File: tb/tb_rans_table_loader.sv
module tb_rans_table_loader;

  localparam int unsigned R  = 10;
  localparam int unsigned S  = 2;
  localparam int unsigned N  = 1 << S;
  localparam int unsigned AW = S + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         fvalid;
  logic         fready;
  logic [R-1:0] freq;
  logic         busy;
  logic         done;
  logic         err;

  axi_lite_if #(.ADDR_W(AW), .DATA_W(32)) mem_if ();

  rans_table_loader #(.RESOLUTION(R), .SYMBOL_WIDTH(S)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .freq_valid_i (fvalid),
    .freq_ready_o (fready),
    .freq_i       (freq),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .mem_if       (mem_if.master)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int               aw_stall;
  int               w_stall;
  int               err_addr;
  logic             aw_got, w_got;
  int               aw_cnt, w_cnt;
  logic [AW-1:0]    lat_addr, a_now;
  logic [31:0]      lat_data, d_now;
  logic [AW-1:0]    log_addr[$];
  logic [31:0]      log_data[$];
  int unsigned      b_total = 0;

  assign mem_if.awready = !aw_got && (aw_cnt >= aw_stall);
  assign mem_if.wready  = !w_got && (w_cnt >= w_stall);
  assign mem_if.arready = 1'b0;
  assign mem_if.rdata   = '0;
  assign mem_if.rresp   = '0;
  assign mem_if.rvalid  = 1'b0;
  assign a_now = aw_got ? lat_addr : mem_if.awaddr;
  assign d_now = w_got ? lat_data : mem_if.wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_cnt        <= 0;
      w_cnt         <= 0;
      lat_addr      <= '0;
      lat_data      <= '0;
      mem_if.bvalid <= 1'b0;
      mem_if.bresp  <= 2'b00;
    end else begin
      if (mem_if.awvalid && mem_if.awready) begin
        aw_got   <= 1'b1;
        lat_addr <= mem_if.awaddr;
      end else if (mem_if.awvalid && !aw_got) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (mem_if.wvalid && mem_if.wready) begin
        w_got    <= 1'b1;
        lat_data <= mem_if.wdata;
      end else if (mem_if.wvalid && !w_got) begin
        w_cnt <= w_cnt + 1;
      end
      if ((aw_got || (mem_if.awvalid && mem_if.awready)) &&
          (w_got || (mem_if.wvalid && mem_if.wready))) begin
        log_addr.push_back(a_now);
        log_data.push_back(d_now);
        mem_if.bvalid <= 1'b1;
        mem_if.bresp  <= (int'(a_now) == err_addr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        aw_cnt <= 0;
        w_cnt  <= 0;
      end
      if (mem_if.bvalid && mem_if.bready) begin
        mem_if.bvalid <= 1'b0;
        b_total       <= b_total + 1;
      end
    end
  end

  // ---------------- protocol / activity monitor ----------------
  int unsigned   done_total = 0;
  int unsigned   busy_total = 0;
  int unsigned   viol_total = 0;
  logic          p_aw_stall = 1'b0;
  logic          p_w_stall  = 1'b0;
  logic          p_w_hs     = 1'b0;
  logic [AW-1:0] p_awaddr   = '0;
  logic [31:0]   p_wdata    = '0;

  always @(negedge clk) begin
    done_total <= done_total + int'(done);
    busy_total <= busy_total + int'(busy);
    if (rst_n) begin
      viol_total <= viol_total
                  + int'(p_aw_stall && (!mem_if.awvalid || mem_if.awaddr != p_awaddr))
                  + int'(p_w_stall && (!mem_if.wvalid || mem_if.wdata != p_wdata))
                  + int'(p_w_hs && mem_if.wvalid);
    end
    p_aw_stall <= rst_n && mem_if.awvalid && !mem_if.awready;
    p_w_stall  <= rst_n && mem_if.wvalid && !mem_if.wready;
    p_w_hs     <= rst_n && mem_if.wvalid && mem_if.wready;
    p_awaddr   <= mem_if.awaddr;
    p_wdata    <= mem_if.wdata;
  end

  // ---------------- stimulus ----------------
  int unsigned cur_freqs[$];
  int unsigned cur_gap;
  bit          load_over;

  task automatic feed();
    foreach (cur_freqs[i]) begin
      int unsigned w;
      for (int unsigned g = 0; g < cur_gap && !load_over; g++) begin
        fvalid = 1'b0;
        @(negedge clk);
      end
      if (load_over) break;
      fvalid = 1'b1;
      freq   = R'(cur_freqs[i]);
      w = 0;
      while (!fready && !load_over && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (load_over) break;
      check($sformatf("feed_ready%0d", i), fready, 1'b1);
      @(negedge clk);
    end
    fvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned c = 0;
    while (!done && c < 800) begin
      @(negedge clk);
      c++;
    end
    check({name, "/done_seen"}, done, 1'b1);
  endtask

  task automatic run_load(input string name);
    logic [AW-1:0] ea[$];
    logic [31:0]   ed[$];
    bit            exp_err = 0;
    bit            sum_bad = 0;
    int unsigned   cum = 0;
    int unsigned   nsym_w = 0;
    int unsigned   rst_w = 0;
    int unsigned   m;
    int unsigned   base_log, base_b, base_done, base_busy, base_viol, nobs;

    // Reference: one {freq, cum mod 2^R} word per symbol, then the restart.
    for (int i = 0; i < int'(N); i++) begin
      ea.push_back(AW'(i));
      ed.push_back((cur_freqs[i] << R) | (cum % (1 << R)));
      nsym_w++;
      if (i == err_addr) begin
        exp_err = 1;
        break;
      end
      cum += cur_freqs[i];
    end
    if (!exp_err) begin
`ifdef RANS_LOADER_SUM_CHECK_EN
      sum_bad = (cum != (1 << R));
`endif
      if (sum_bad) begin
        exp_err = 1;
      end else begin
        ea.push_back(AW'(N));
        ed.push_back(32'h0);
        rst_w = 1;
        if (err_addr == int'(N)) exp_err = 1;
      end
    end

    base_log  = log_addr.size();
    base_b    = b_total;
    base_done = done_total;
    base_busy = busy_total;
    base_viol = viol_total;
    load_over = 0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "/busy_after_start"}, busy, 1'b1);
    check({name, "/ready_after_start"}, fready, 1'b1);
    check({name, "/err_cleared"}, err, 1'b0);

    fork
      feed();
      begin
        wait_done(name);
        load_over = 1;
      end
    join

    repeat (3) @(negedge clk);
    nobs = log_addr.size() - base_log;
    check({name, "/n_writes"}, nobs, ea.size());
    for (int i = 0; i < ea.size() && i < int'(nobs); i++) begin
      check($sformatf("%s/addr%0d", name, i), log_addr[base_log + i], ea[i]);
      check($sformatf("%s/data%0d", name, i), log_data[base_log + i], ed[i]);
    end
    check({name, "/err"}, err, exp_err);
    check({name, "/done_pulses"}, done_total - base_done, 1);
    check({name, "/b_handshakes"}, b_total - base_b, ea.size());
    check({name, "/protocol"}, viol_total - base_viol, 0);
    check({name, "/idle_after"}, busy, 1'b0);
    if (cur_gap == 0) begin
      m = (aw_stall > w_stall) ? aw_stall : w_stall;
      check({name, "/busy_cycles"}, busy_total - base_busy,
            nsym_w * (3 + m) + rst_w * (2 + m) + 1);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "/outs_zero"},
          {fready, busy, done, err, mem_if.awvalid, mem_if.wvalid, mem_if.bready,
           mem_if.awaddr, mem_if.wdata}, '0);
  endtask

  task automatic set_freqs(input int unsigned f0, input int unsigned f1,
                           input int unsigned f2, input int unsigned f3);
    cur_freqs.delete();
    cur_freqs.push_back(f0);
    cur_freqs.push_back(f1);
    cur_freqs.push_back(f2);
    cur_freqs.push_back(f3);
  endtask

  initial begin
    int unsigned base_log;
    int unsigned c;

    rst_n     = 1'b0;
    start     = 1'b0;
    fvalid    = 1'b0;
    freq      = '0;
    aw_stall  = 0;
    w_stall   = 0;
    err_addr  = -1;
    cur_gap   = 0;
    load_over = 0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset/ar_tieoff", {mem_if.arvalid, mem_if.rready}, 2'b01);
    check("reset/wstrb_prot", {mem_if.wstrb, mem_if.awprot}, 7'b1111_000);
    rst_n = 1'b1;
    @(negedge clk);

    set_freqs(256, 256, 256, 256);
    run_load("base");

    set_freqs(256, 256, 256, 255);
    run_load("sum");

    set_freqs(256, 256, 256, 256);
    err_addr = 1;
    run_load("bresp_err");
    check("bresp_err/err_sticky", err, 1'b1);
    err_addr = -1;
    run_load("err_clear");

    aw_stall = 3;
    w_stall  = 0;
    run_load("aw_stall");
    aw_stall = 0;

    cur_gap = 5;
    run_load("gap");
    cur_gap = 0;

    // Reset while the response for symbol 2 is pending.
    base_log  = log_addr.size();
    load_over = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      feed();
      begin
        c = 0;
        while (log_addr.size() < base_log + 3 && c < 400) begin
          @(negedge clk);
          c++;
        end
        check("midrst/reached_resp2", log_addr.size() - base_log, 3);
        check("midrst/in_resp", mem_if.bready, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        load_over = 1;
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst/no_restart", log_addr.size() - base_log, 3);
    set_freqs(100, 200, 300, 424);
    run_load("after_reset");

    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) begin
        int unsigned a, b, d;
        a = $urandom_range(1, 340);
        b = $urandom_range(1, 340);
        d = $urandom_range(1, 340);
        set_freqs(a, b, d, 1024 - a - b - d);
      end else begin
        set_freqs($urandom_range(0, 511), $urandom_range(0, 511),
                  $urandom_range(0, 511), $urandom_range(0, 511));
      end
      aw_stall = $urandom_range(0, 3);
      w_stall  = $urandom_range(0, 3);
      cur_gap  = $urandom_range(0, 2);
      err_addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : -1;
      run_load($sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
